id_ex_latch: RTL
================

// Module: id_ex_latch
// PURPOSE
//  ID/EX pipeline register. Sits directly upstream of the forwarding unit and feeds it rs/rt/rs_v/rt_v.
//  Detects load-use hazards and inserts one bubble per hazard. Honours downstream stall and EX-stage flush.
//  Freezes issue after a HALT enters EX. Counts inserted bubbles for performance debug.
// PARAMETERS
//  CTRL_W   8   width of opaque decoded-control bundle passed through to EX
//  CNT_W    16  width of saturating bubble counter
// PORTS
//  clk          in   1       single clock, all state on posedge
//  rst          in   1       synchronous, active-high reset
//  id_valid     in   1       decode slot holds a real instruction
//  id_rs        in   3       source reg A
//  id_rt        in   3       source reg B
//  id_rs_v      in   1       rs actually read
//  id_rt_v      in   1       rt actually read
//  id_wr        in   1       instruction writes a register
//  id_rd        in   3       destination reg
//  id_memrd     in   1       load
//  id_memwr     in   1       store
//  id_halt      in   1       HALT instruction
//  id_pc        in   16      PC+2 of decode instruction
//  id_imm       in   16      sign/zero-extended immediate
//  id_ctrl      in   CTRL_W  ALU/branch control bundle
//  ex_flush     in   1       EX resolved a taken/mispredicted branch; kill decode slot
//  mem_stall    in   1       downstream (memory) stall; hold everything
//  stall_if_id  out  1       hold PC and IF/ID this cycle (combinational)
//  ex_valid, ex_rs, ex_rt, ex_rs_v, ex_rt_v, ex_wr, ex_rd, ex_memrd, ex_memwr, ex_halt, ex_pc, ex_imm, ex_ctrl
//               out  same widths as id_* counterparts; registered
//  halted       out  1       HALT has entered EX; issue frozen
//  bubble_cnt   out  CNT_W   bubbles inserted by load-use since reset
// BEHAVIOUR
//  Reset: all ex_* = 0, halted = 0, bubble_cnt = 0. stall_if_id = 0 while rst is high.
//  Bubble: ex_valid = ex_wr = ex_memrd = ex_memwr = ex_halt = 0, ex_rs_v = ex_rt_v = 0.
//   Other fields are don't-care but driven 0.
//  Load-use (lu, combinational):
//   ex_valid & ex_memrd & ex_wr & id_valid & ((id_rs_v & id_rs==ex_rd) | (id_rt_v & id_rt==ex_rd)).
//  A store's data source (rt) counts as a use. No exception for R0.
//  Priority per cycle, highest first:
//   1 rst: reset values.
//   2 ex_flush: load bubble; stall_if_id=0. Flush wins over mem_stall and lu.
//   3 mem_stall: hold all ex_*; stall_if_id=1.
//   4 halted: load bubble; stall_if_id=1.
//   5 lu: load bubble; stall_if_id=1; bubble_cnt += 1, saturating at all-ones.
//   6 else: ex_* <= id_* (id_valid=0 loads a bubble); stall_if_id=0.
//  Latency 1 cycle id_* -> ex_*. Exactly one bubble per load-use; the consumer receives MEM/WB forwarding.
//  FSM: RUN -> HALTED when an instruction with id_halt & id_valid is latched (case 6).
//   HALTED -> RUN only on rst. ex_flush in HALTED still loads a bubble and does not leave HALTED.
//  Back-to-back loads: each dependent consumer stalls once. A load whose own rs depends on a prior load stalls like any consumer.
//  lu and stall_if_id are purely combinational from current ex_* and id_* (no extra state).
//  Reset mid-operation (during stall or HALTED) returns to RUN with an empty slot next cycle.
// STRUCTURE
//  Shared package (pipe_pkg): CTRL_W, REG_W=3, WORD_W=16, and the bubble constant for the ex_* bundle.
//  One sub-module is natural: load_use_detect (combinational lu compare), reused by any future 2-cycle-load variant.
//  Pipeline register is flat in this module with a single enable/clear decode.
// TESTING
//  1 LD R3,(R1) then ADD R4,R3,R2 -> cycle 2: stall_if_id=1, ex_valid=0; cycle 3: ex_rs=3 ex_valid=1; bubble_cnt=1.
//  2 LD R3 then ST R3 with rt=3, rt_v=1 -> one bubble. Same pair with rt_v=0 -> no bubble, bubble_cnt unchanged.
//  3 mem_stall=1 for 3 cycles with ADD in EX -> ex_* unchanged all 3 cycles; stall_if_id=1; releases on the 4th cycle.
//  4 ex_flush=1 with mem_stall=1 and lu=1 simultaneously -> next ex_valid=0, stall_if_id=0, bubble_cnt unchanged.
//  5 HALT latched -> halted=1 next cycle; further id_valid instructions yield ex_valid=0, stall_if_id=1; rst clears halted.
//  6 Force bubble_cnt to 16'hFFFF, trigger lu -> stays 16'hFFFF. rst asserted during lu stall -> all ex_*=0, cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the ID/EX boundary: field widths, the EX-slot
// bundle (minus the opaque control word) and its bubble value.
package pipe_pkg;

  localparam int CTRL_W = 8;
  localparam int REG_W  = 3;
  localparam int WORD_W = 16;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic              rs_v;
    logic              rt_v;
    logic              wr;
    logic [REG_W-1:0]  rd;
    logic              memrd;
    logic              memwr;
    logic              halt;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] imm;
  } ex_fields_t;

  localparam ex_fields_t EX_BUBBLE = '0;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HALTED  = 1'b1
  } run_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use compare between the load sitting in EX and the instruction in
// decode. R0 gets no special treatment; a store's rt counts as a use.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic             ex_valid_i,
  input  logic             ex_memrd_i,
  input  logic             ex_wr_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic             id_rs_v_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_rt_v_i,
  output logic             lu_o
);

  logic ex_is_load;
  logic rs_hit;
  logic rt_hit;

  assign ex_is_load = ex_valid_i & ex_memrd_i & ex_wr_i;
  assign rs_hit     = id_rs_v_i & (id_rs_i == ex_rd_i);
  assign rt_hit     = id_rt_v_i & (id_rt_i == ex_rd_i);
  assign lu_o       = ex_is_load & id_valid_i & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use bubble insertion, stall/flush
// handling, HALT freeze and a saturating bubble counter.
//   state      | meaning
//   ST_RUN     | normal issue from decode
//   ST_HALTED  | HALT reached EX; only bubbles issue until reset
module id_ex_latch
  import pipe_pkg::*;
#(
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_rs_v,
  input  logic              id_rt_v,
  input  logic              id_wr,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_memrd,
  input  logic              id_memwr,
  input  logic              id_halt,
  input  logic [WORD_W-1:0] id_pc,
  input  logic [WORD_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_flush,
  input  logic              mem_stall,
  output logic              stall_if_id,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic              ex_rs_v,
  output logic              ex_rt_v,
  output logic              ex_wr,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_memrd,
  output logic              ex_memwr,
  output logic              ex_halt,
  output logic [WORD_W-1:0] ex_pc,
  output logic [WORD_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              halted,
  output logic [CNT_W-1:0]  bubble_cnt
);

  ex_fields_t        ex_q;
  ex_fields_t        id_f;
  logic [CTRL_W-1:0] ctrl_q;
  run_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;

  logic lu;
  logic load_en;
  logic clr;
  logic stall;
  logic cnt_inc;

  assign id_f = '{valid: id_valid, rs: id_rs, rt: id_rt, rs_v: id_rs_v,
                  rt_v: id_rt_v, wr: id_wr, rd: id_rd, memrd: id_memrd,
                  memwr: id_memwr, halt: id_halt, pc: id_pc, imm: id_imm};

  load_use_detect u_lud (
    .ex_valid_i (ex_q.valid),
    .ex_memrd_i (ex_q.memrd),
    .ex_wr_i    (ex_q.wr),
    .ex_rd_i    (ex_q.rd),
    .id_valid_i (id_valid),
    .id_rs_i    (id_rs),
    .id_rs_v_i  (id_rs_v),
    .id_rt_i    (id_rt),
    .id_rt_v_i  (id_rt_v),
    .lu_o       (lu)
  );

  // Single enable/clear decode; order encodes flush > stall > halted > lu.
  always_comb begin
    load_en = 1'b1;
    clr     = 1'b0;
    stall   = 1'b0;
    cnt_inc = 1'b0;
    if (ex_flush) begin
      clr = 1'b1;
    end else if (mem_stall) begin
      load_en = 1'b0;
      stall   = 1'b1;
    end else if (state_q == ST_HALTED) begin
      clr   = 1'b1;
      stall = 1'b1;
    end else if (lu) begin
      clr     = 1'b1;
      stall   = 1'b1;
      cnt_inc = 1'b1;
    end else if (!id_valid) begin
      clr = 1'b1;
    end
  end

  assign stall_if_id = stall & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= EX_BUBBLE;
      ctrl_q  <= '0;
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      if (load_en) begin
        if (clr) begin
          ex_q   <= EX_BUBBLE;
          ctrl_q <= '0;
        end else begin
          ex_q   <= id_f;
          ctrl_q <= id_ctrl;
          if (id_halt) state_q <= ST_HALTED;
        end
      end
      if (cnt_inc && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_rs      = ex_q.rs;
  assign ex_rt      = ex_q.rt;
  assign ex_rs_v    = ex_q.rs_v;
  assign ex_rt_v    = ex_q.rt_v;
  assign ex_wr      = ex_q.wr;
  assign ex_rd      = ex_q.rd;
  assign ex_memrd   = ex_q.memrd;
  assign ex_memwr   = ex_q.memwr;
  assign ex_halt    = ex_q.halt;
  assign ex_pc      = ex_q.pc;
  assign ex_imm     = ex_q.imm;
  assign ex_ctrl    = ctrl_q;
  assign halted     = (state_q == ST_HALTED);
  assign bubble_cnt = cnt_q;

endmodule
